// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer, RAM address, read-pointer sync and full/almost-full/occupancy/overflow flags
module wptr_full #(
    parameter int ADDRSIZE    = 8,
    parameter int AFULL_LEVEL = 252
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   rptr_in,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);
    localparam logic [ADDRSIZE:0] AFL = (ADDRSIZE+1)'(AFULL_LEVEL);
    logic [ADDRSIZE:0] wbin, wbnext, wgnext, rq1, rq2, rbin_s, wdiff;
    logic              wacc;
    always_comb begin
        wacc   = winc & ~wfull;
        wbnext = wbin + (ADDRSIZE+1)'(wacc);
        wgnext = (wbnext >> 1) ^ wbnext;
        for (int i = 0; i <= ADDRSIZE; i++) rbin_s[i] = ^(rq2 >> i);
        wdiff  = wbnext - rbin_s;
    end
    // Full when the next Gray write pointer is one lap ahead of the synchronized read pointer
    always_ff @(posedge wclk) begin
        if (wrst) begin
            rq1          <= '0;
            rq2          <= '0;
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            rq1          <= rptr_in;
            rq2          <= rq1;
            wbin         <= wbnext;
            wptr         <= wgnext;
            wfull        <= wgnext == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]};
            walmost_full <= wdiff >= AFL;
            wcount       <= wdiff;
            woverflow    <= (winc & wfull) | (woverflow & ~wovf_clr);
        end
    end
    assign waddr = wbin[ADDRSIZE-1:0];
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: table-driven and scoreboarded bench for wptr_full (ADDRSIZE=3, AFULL_LEVEL=6)
module tb_wptr_full;
    typedef struct packed {
        logic [3:0] ptr;
        logic [2:0] addr;
        logic       full;
        logic       af;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;
    typedef struct packed {
        logic       r;
        logic       inc;
        logic       clr;
        logic [3:0] rp;
        exp_t       e;
    } vec_t;

    logic       wclk = 0, wrst = 1, winc = 0, wovf_clr = 0;
    logic [3:0] rptr_in = '0;
    logic [2:0] waddr;
    logic [3:0] wptr, wcount;
    logic       wfull, walmost_full, woverflow;
    int         checks = 0, errors = 0;
    exp_t       sb[$];
    vec_t       tbl[20];

    wptr_full #(.ADDRSIZE(3), .AFULL_LEVEL(6)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr), .rptr_in(rptr_in),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wcount(wcount), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t mk(logic [3:0] p, logic [2:0] a, logic f, logic af, logic [3:0] c, logic o);
        mk = '{ptr: p, addr: a, full: f, af: af, cnt: c, ovf: o};
    endfunction

    function automatic vec_t mv(logic r, logic i, logic c, logic [3:0] rp, exp_t e);
        mv = '{r: r, inc: i, clr: c, rp: rp, e: e};
    endfunction

    function automatic logic [3:0] gray(logic [3:0] b);
        gray = b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(logic [3:0] g);
        g2b = {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic i, input logic c, input logic [3:0] rp, input exp_t e);
        exp_t x;
        wrst = r; winc = i; wovf_clr = c; rptr_in = rp;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        x = sb.pop_front();
        chk("wptr", int'(wptr), int'(x.ptr));
        chk("waddr", int'(waddr), int'(x.addr));
        chk("wfull", int'(wfull), int'(x.full));
        chk("walmost_full", int'(walmost_full), int'(x.af));
        chk("wcount", int'(wcount), int'(x.cnt));
        chk("woverflow", int'(woverflow), int'(x.ovf));
    endtask

    initial begin
        logic [3:0] mb, nb, r1, r2, rp, c, prev;
        logic       w;
        tbl[0]  = mv(1, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        tbl[1]  = mv(1, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        tbl[2]  = mv(0, 1, 0, 4'b0000, mk(4'b0001, 1, 0, 0, 1, 0));
        tbl[3]  = mv(0, 1, 0, 4'b0000, mk(4'b0011, 2, 0, 0, 2, 0));
        tbl[4]  = mv(0, 1, 0, 4'b0000, mk(4'b0010, 3, 0, 0, 3, 0));
        tbl[5]  = mv(0, 1, 0, 4'b0000, mk(4'b0110, 4, 0, 0, 4, 0));
        tbl[6]  = mv(0, 1, 0, 4'b0000, mk(4'b0111, 5, 0, 0, 5, 0));
        tbl[7]  = mv(0, 1, 0, 4'b0000, mk(4'b0101, 6, 0, 1, 6, 0));
        tbl[8]  = mv(0, 1, 0, 4'b0000, mk(4'b0100, 7, 0, 1, 7, 0));
        tbl[9]  = mv(0, 1, 0, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 0));
        tbl[10] = mv(0, 1, 0, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[11] = mv(0, 1, 0, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[12] = mv(0, 1, 0, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[13] = mv(0, 0, 1, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 0));
        tbl[14] = mv(0, 1, 1, 4'b0000, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[15] = mv(0, 0, 0, 4'b0011, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[16] = mv(0, 0, 0, 4'b0011, mk(4'b1100, 0, 1, 1, 8, 1));
        tbl[17] = mv(0, 0, 0, 4'b0011, mk(4'b1100, 0, 0, 1, 6, 1));
        tbl[18] = mv(0, 1, 0, 4'b0011, mk(4'b1101, 1, 0, 1, 7, 1));
        tbl[19] = mv(0, 0, 1, 4'b0011, mk(4'b1101, 1, 0, 1, 7, 0));
        for (int i = 0; i < 20; i++) step(tbl[i].r, tbl[i].inc, tbl[i].clr, tbl[i].rp, tbl[i].e);
        // Streaming across the pointer wrap with the read pointer trailing; two idle priming edges first
        mb = 4'd9; r1 = 4'b0011; r2 = 4'b0011;
        for (int i = 0; i < 27; i++) begin
            w    = i >= 2;
            rp   = w ? gray(mb - 4'd2) : gray(4'd7);
            nb   = mb + {3'b000, w};
            c    = nb - g2b(r2);
            prev = wptr;
            step(0, w, 0, rp, mk(gray(nb), nb[2:0], 0, c >= 4'd6, c, 0));
            chk("gray_single_step", $countones(prev ^ wptr), int'(w));
            r2 = r1; r1 = rp; mb = nb;
        end
        step(1, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        step(0, 1, 0, 4'b0000, mk(4'b0001, 1, 0, 0, 1, 0));
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
